// File: rtl/image_stream_buffer_pkg.sv
// Shared definitions for the double-banked image stream buffer.
package image_stream_buffer_pkg;

  localparam int INT_WIDTH      = 8;
  localparam int IMG_BUF_DEPTH  = 1024;
  localparam int IMG_BUF_ADDR_W = $clog2(IMG_BUF_DEPTH);

  typedef logic [15:0] img_pix_cnt_t;

  // Full-width pixel count; the 8x8 product never truncates in 16 bits.
  function automatic img_pix_cnt_t img_pix_cnt(input logic [7:0] w, input logic [7:0] h);
    return img_pix_cnt_t'(w) * img_pix_cnt_t'(h);
  endfunction

endpackage

// File: rtl/img_buf_bank.sv
// One image bank: synchronous write port and registered read port, no reset on storage.
module img_buf_bank
  import image_stream_buffer_pkg::*;
#(
  parameter int DATA_W = INT_WIDTH,
  parameter int DEPTH  = IMG_BUF_DEPTH,
  parameter int ADDR_W = IMG_BUF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/image_stream_buffer.sv
// Double-banked image buffer: host fills one bank while the wrapper reads the other.
// Optional s_last_i consistency checking is enabled by defining IMG_BUF_LAST_CHECK_EN.
module image_stream_buffer
  import image_stream_buffer_pkg::*;
#(
  parameter int DATA_W = INT_WIDTH,
  parameter int DEPTH  = IMG_BUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_async_i,
  input  logic [7:0]        cfg_img_w_i,
  input  logic [7:0]        cfg_img_h_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  input  logic              rom_rd_en_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  input  logic              consume_done_i,
  output logic              rd_bank_valid_o,
  output logic              err_oob_o,
  output logic              err_last_o
);

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full_cnt;
  logic [ADDR_W-1:0] wr_addr;
  img_pix_cnt_t      npix [2];

  logic              accept;
  logic              bank_done;
  logic              release_ok;
  logic              rd_illegal;
  img_pix_cnt_t      npix_cur;
  logic [DATA_W-1:0] bank_rd_data [2];

  logic              sel_p1;
  logic              zero_p1;

  assign s_ready_o       = (full_cnt < 2'd2);
  assign rd_bank_valid_o = (full_cnt != 2'd0);
  assign accept          = s_valid_i && s_ready_o;
  assign release_ok      = consume_done_i && rd_bank_valid_o;

  // The first beat of a bank uses the live configuration; later beats use the latched count.
  assign npix_cur  = (wr_addr == '0) ? img_pix_cnt(cfg_img_w_i, cfg_img_h_i) : npix[wr_bank];
  assign bank_done = accept && (32'(wr_addr) == (32'(npix_cur) - 32'd1));

  assign rd_illegal = !rd_bank_valid_o || (32'(rom_addr_i) >= 32'(npix[rd_bank]));

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full_cnt <= 2'd0;
      wr_addr  <= '0;
      npix[0]  <= '0;
      npix[1]  <= '0;
    end else begin
      if (accept) begin
        if (wr_addr == '0) npix[wr_bank] <= npix_cur;
        wr_addr <= bank_done ? '0 : wr_addr + ADDR_W'(1);
      end
      if (bank_done)  wr_bank <= ~wr_bank;
      if (release_ok) rd_bank <= ~rd_bank;
      case ({bank_done, release_ok})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    img_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk_i     (clk_i),
      .wr_en_i   (accept && (wr_bank == 1'(b))),
      .wr_addr_i (wr_addr),
      .wr_data_i (s_data_i),
      .rd_en_i   (rom_rd_en_i && (rd_bank == 1'(b))),
      .rd_addr_i (rom_addr_i),
      .rd_data_o (bank_rd_data[b])
    );
  end

  // Stage p1: bank select and zero-forcing travel with the registered bank read.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      sel_p1    <= 1'b0;
      zero_p1   <= 1'b1;
      err_oob_o <= 1'b0;
    end else if (rom_rd_en_i) begin
      sel_p1  <= rd_bank;
      zero_p1 <= rd_illegal;
      if (rd_illegal) err_oob_o <= 1'b1;
    end
  end

  assign rom_data_o = zero_p1 ? '0 : bank_rd_data[sel_p1];

`ifdef IMG_BUF_LAST_CHECK_EN
  logic err_last_q;

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i)                             err_last_q <= 1'b0;
    else if (accept && (s_last_i != bank_done))  err_last_q <= 1'b1;
  end

  assign err_last_o = err_last_q;
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign err_last_o  = 1'b0;
`endif

endmodule

// File: doc/image_stream_buffer.md
# image_stream_buffer

Double-banked image buffer that is the responder end of the systolic wrapper's image ROM read port (`rom_rd_en`/`rom_addr` in, `rom_data` out, 1-cycle latency). It replaces the fixed image ROM: a host streams pixels in over a valid/ready interface, and the wrapper reads one complete image from one bank while the next image fills the other bank. It sits between the host DMA/stream and `systolic_wrapper`.

## Interface
- `DATA_W`, default 8: pixel width; equals `INT_WIDTH`.
- `DEPTH`, default 1024: words per bank; must be at least the largest `cfg_img_w_i*cfg_img_h_i`.
- `ADDR_W`, default `$clog2(DEPTH)`: read/write address width.
- `clk_i`  in  1: clock; all logic is on the rising edge.
- `rst_async_i`  in  1: asynchronous, active-high reset.
- `cfg_img_w_i`, `cfg_img_h_i`  in  8 each: image dimensions; sampled per bank.
- `s_valid_i`  in  1; `s_ready_o`  out  1; `s_data_i`  in  `DATA_W`: pixel fill stream, raster order.
- `s_last_i`  in  1: marks the final pixel of an image.
- `rom_rd_en_i`  in  1; `rom_addr_i`  in  `ADDR_W`; `rom_data_o`  out  `DATA_W`: responder read port.
- `consume_done_i`  in  1: single-cycle pulse from the consumer (the wrapper's `done_o`); releases the current read bank.
- `rd_bank_valid_o`  out  1: a full bank is presented on the read port.
- `err_oob_o`  out  1: sticky; an illegal read occurred.
- `err_last_o`  out  1: sticky; `s_last_i` mismatch.

## Operation
- **State:**
  - `wr_bank`, `rd_bank` (1 bit each).
  - `full_cnt` (0..2).
  - `wr_addr` (`ADDR_W`).
  - `npix[2]`: a per-bank pixel count of 16 bits.
- **Fill:**
  - A beat is accepted when `s_valid_i && s_ready_o`; it writes `mem[wr_bank][wr_addr]` and increments `wr_addr`.
  - On the first beat of a bank (`wr_addr==0`), `npix[wr_bank]` is latched as `cfg_img_w_i*cfg_img_h_i`. The product is computed at full 16-bit width, with no truncation.
  - When the accepted beat has `wr_addr==npix-1`, the bank is full: `wr_addr` resets to 0, `wr_bank` toggles, and `full_cnt` increments.
- **Backpressure:** `s_ready_o = (full_cnt<2)`.
- **Read:**
  - `rd_bank_valid_o = (full_cnt>0)`.
  - A read with `rom_rd_en_i` high returns `mem[rd_bank][rom_addr_i]` on the next cycle.
- **Illegal reads:** a read with `!rd_bank_valid_o`, or with `rom_addr_i >= npix[rd_bank]`, returns 0 and sets `err_oob_o`.
- **Release:**
  - When `consume_done_i` is high and `full_cnt>0`, `rd_bank` toggles and `full_cnt` decrements.
  - When `consume_done_i` is high and `full_cnt==0`, the pulse is ignored with no error.
- **Simultaneous completion:** a bank completing and a release in the same cycle leave `full_cnt` unchanged; both bank pointers toggle.
- **Mid-image reset:** an asynchronous reset clears all state; memory contents are not cleared. After reset, all banks are treated as empty.

## Timing
- **Reset values:**
  - `s_ready_o` = 1.
  - `rd_bank_valid_o` = 0.
  - `rom_data_o` = 0.
  - `err_oob_o` = 0.
  - `err_last_o` = 0.
  - Internal pointers and counters = 0.
- **Read latency:** exactly 1 cycle, registered. `rom_data_o` holds its last value while `rom_rd_en_i` is low.
- **Write-to-read visibility:** the cycle after the final beat is accepted, `rd_bank_valid_o` rises if `full_cnt` was 0.
- **Fill throughput:** one beat per cycle sustained; no bubbles at the bank switch.
- **Release timing:** a `consume_done_i` pulse in cycle N switches `rd_bank` for reads issued in cycle N+1. `s_ready_o` reasserts in N+1 if it was low.
- **Same-address read and write:** reads and writes never target the same bank, because the fill bank is never the read bank while `full_cnt>0`.

## Configuration
- Macro: `IMG_BUF_LAST_CHECK_EN`.
- **Defined:** on an accepted beat, `s_last_i != (wr_addr==npix-1)` sets `err_last_o`. Bank completion still follows `npix`.
- **Undefined:** `s_last_i` is ignored and `err_last_o` is tied to 0.

## Structure
- **Shared package:** `INT_WIDTH` (reused), `IMG_BUF_DEPTH`, `IMG_BUF_ADDR_W`, and the 16-bit pixel-count typedef `img_pix_cnt_t`.
- **Sub-module `img_buf_bank`:** one bank with one synchronous write port and one registered read port, instantiated twice. The top level multiplexes the two banks by `rd_bank` on the registered output.

## Test plan
- **Single image fill and read:**
  - Stimulus: 28x28 config; fill 784 beats with values `i%256`; then read addresses 0, 1 and 783.
  - Response: `rd_bank_valid_o` rises the cycle after beat 783; data 0, 1 and 15 (783%256) arrives 1 cycle after each read.
- **Backpressure:**
  - Stimulus: stream 3 images with `consume_done_i` never pulsed.
  - Response: `s_ready_o` drops after the 1568th beat; pulsing `consume_done_i` once reasserts it the next cycle.
- **Ping-pong:**
  - Stimulus: image A (all 0x11) and image B (all 0x22) both loaded; read address 5, pulse `consume_done_i`, read address 5 again.
  - Response: 0x11, then 0x22.
- **Simultaneous completion and release:**
  - Stimulus: `full_cnt==1`; the final beat of bank B coincides with `consume_done_i`.
  - Response: `full_cnt` stays 1 and `rd_bank_valid_o` stays 1.
- **Out-of-bounds reads:**
  - Stimulus: read address 784 on a 28x28 bank; separately, read with no full bank.
  - Response: `rom_data_o`=0 and `err_oob_o` is set, sticky until reset.
- **Mid-fill reset:**
  - Stimulus: assert `rst_async_i` at beat 400, then refill.
  - Response: all outputs go to reset values immediately; the refill starts at `wr_addr` 0. With the macro defined, early `s_last_i` at beat 10 sets `err_last_o`.
